ro_freq_meter_ctrl: RTL and testbench

//   Sequencer that measures a bank of NUM_RO ring oscillators one at a time.
//   Per oscillator: enable only that ring, wait a settle window, count its rising edges over a fixed gate window.

---
 rtl/ro_ctrl_pkg.sv | 17 +
 rtl/osc_edge_sync.sv | 17 +
 rtl/ro_freq_meter_ctrl.sv | 118 +++++++++++
 tb/tb_ro_freq_meter_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ro_ctrl_pkg.sv
// Shared constants for the ring-oscillator frequency meter and its CSR block.
package ro_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_GATE_CYCLES   = 1024;

  // Width of a down-counter that must hold 0..v-1 (never narrower than 1 bit).
  function automatic int clogMin1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for an asynchronous ring output plus a rising-edge pulse.
module osc_edge_sync (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iOsc,
  output logic oRise
);
  // sh[0], sh[1] synchronise; sh[2] is the previous synchronised level
  logic [2:0] sh;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) sh <= '0;
    else         sh <= {sh[1:0], iOsc};
  end

  assign oRise = sh[1] & ~sh[2];
endmodule

// File: rtl/ro_freq_meter_ctrl.sv
// Sweeps a ring-oscillator bank: enable one ring, settle, count edges over a gate
// window, then hold {idx, count} on a valid/ready output until accepted.
module ro_freq_meter_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int NUM_RO        = 4,
  parameter int IDX_W         = 2,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iContinuous,
  input  logic [NUM_RO-1:0] iRoOsc,
  output logic [NUM_RO-1:0] oRoEn,
  output logic [IDX_W-1:0]  oIdx,
  output logic [CNT_W-1:0]  oCount,
  output logic              oOvf,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy
);
  localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMR_W   = clogMin1(TMR_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RO - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD    = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state, stateNxt;
  logic [IDX_W-1:0]  idx, idxNxt;
  logic [TMR_W-1:0]  tmr, tmrNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic              ovf, ovfNxt;
  logic              oscSel, rise;

  // Select is fixed from SETTLE onward, so the synchroniser is flushed before GATE.
  assign oscSel = iRoOsc[idx];

  osc_edge_sync uSync (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iOsc   (oscSel),
    .oRise  (rise)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      tmr   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
      tmr   <= tmrNxt;
      cnt   <= cntNxt;
      ovf   <= ovfNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    tmrNxt   = tmr;
    cntNxt   = cnt;
    ovfNxt   = ovf;
    case (state)
      S_IDLE: if (iStart) begin
        stateNxt = S_SETTLE;
        idxNxt   = '0;
        tmrNxt   = SETTLE_LD;
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          stateNxt = S_GATE;
          tmrNxt   = GATE_LD;
          cntNxt   = '0;
          ovfNxt   = 1'b0;
        end else begin
          tmrNxt = tmr - TMR_W'(1);
        end
      end
      S_GATE: begin
        if (rise) begin
          if (cnt == CNT_MAX) ovfNxt = 1'b1;
          else                cntNxt = cnt + CNT_W'(1);
        end
        if (tmr == '0) stateNxt = S_HOLD;
        else           tmrNxt   = tmr - TMR_W'(1);
      end
      S_HOLD: if (iReady) begin
        tmrNxt = SETTLE_LD;
        if (idx != LAST_IDX) begin
          idxNxt   = idx + IDX_W'(1);
          stateNxt = S_SETTLE;
        end else if (iContinuous) begin
          idxNxt   = '0;
          stateNxt = S_SETTLE;
        end else begin
          stateNxt = S_IDLE;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  // Decoded from registered state: async reset drops every enable at once.
  assign oRoEn  = (state == S_SETTLE || state == S_GATE) ? (NUM_RO'(1) << idx) : '0;
  assign oValid = (state == S_HOLD);
  assign oBusy  = (state != S_IDLE);
  assign oIdx   = idx;
  assign oCount = cnt;
  assign oOvf   = ovf;
endmodule

// File: tb/tb_ro_freq_meter_ctrl.sv
// Scoreboard bench: rings are free-running square waves; expected counts come from GATE/period.
module tb_ro_freq_meter_ctrl;
  localparam int NR = 4, IW = 2, ST = 8, GT = 100, CW = 8, CW3 = 3;
  localparam int LAT = 1 + ST + GT;

  logic iClk = 0, iRst_n = 0, iStart = 0, iContinuous = 0, iReady = 0;
  logic [NR-1:0] iRoOsc = '0;
  logic [NR-1:0] roEn, roEn3;
  logic [IW-1:0] idxA, idx3;
  logic [CW-1:0] cntA;
  logic [CW3-1:0] cnt3;
  logic ovfA, ovf3, vldA, vld3, busyA, busy3;

  ro_freq_meter_ctrl #(.NUM_RO(NR), .IDX_W(IW), .SETTLE_CYCLES(ST), .GATE_CYCLES(GT), .CNT_W(CW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iContinuous(iContinuous), .iRoOsc(iRoOsc),
    .oRoEn(roEn), .oIdx(idxA), .oCount(cntA), .oOvf(ovfA), .oValid(vldA), .iReady(iReady), .oBusy(busyA));

  ro_freq_meter_ctrl #(.NUM_RO(NR), .IDX_W(IW), .SETTLE_CYCLES(ST), .GATE_CYCLES(GT), .CNT_W(CW3)) dut3 (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iContinuous(iContinuous), .iRoOsc(iRoOsc),
    .oRoEn(roEn3), .oIdx(idx3), .oCount(cnt3), .oOvf(ovf3), .oValid(vld3), .iReady(iReady), .oBusy(busy3));

  always #5 iClk = ~iClk;

  typedef struct { int idx; int per; } exp_t;
  exp_t sb[$];
  int per [NR] = '{10, 20, 40, 8};
  int ph  [NR] = '{0, 0, 0, 0};
  int nCmp = 0, nErr = 0;
  int rdyMode = 0;
  logic rdyVal = 1'b1;

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    nCmp++;
    if (!ok) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chkRange(input string nm, input longint act, input longint lo, input longint hi);
    nCmp++;
    if (act < lo || act > hi) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Free-running rings, changing shortly after each clock edge
  initial forever begin
    @(posedge iClk); #3;
    for (int r = 0; r < NR; r++) begin
      ph[r] = (ph[r] + 1) % per[r];
      iRoOsc[r] = (ph[r] < per[r] / 2);
    end
  end

  initial forever begin
    @(posedge iClk); #1;
    iReady = (rdyMode != 0) ? ($urandom_range(0, 3) != 0) : rdyVal;
  end

  // Monitor: samples on the falling edge, pops on each handshake
  logic holdPrev = 0;
  logic [IW-1:0] hIdx;
  logic [CW-1:0] hCnt;
  logic hOvf;
  always @(negedge iClk) begin
    exp_t e;
    int lo, hi;
    if (!iRst_n) holdPrev = 0;
    else begin
      chk("onehot0_en", $onehot0(roEn), roEn, 0);
      chk("lockstep", roEn3 == roEn && vld3 == vldA && busy3 == busyA, {roEn3, vld3, busy3}, {roEn, vldA, busyA});
      if (roEn != 0) begin
        chk("stray_enable", sb.size() != 0, roEn, 0);
        if (sb.size() != 0) chk("ring_sel", roEn == NR'(1 << sb[0].idx), roEn, 1 << sb[0].idx);
      end
      if (vldA) begin
        chk("hold_en_off", roEn == 0, roEn, 0);
        if (holdPrev) begin
          chk("hold_stable", idxA == hIdx && cntA == hCnt && ovfA == hOvf, cntA, hCnt);
        end else begin
          chk("unexpected_valid", sb.size() != 0, idxA, -1);
          if (sb.size() != 0) begin
            e  = sb[0];
            lo = (GT + e.per - 1) / e.per - 1;
            hi = GT / e.per + 1;
            chk("idx", idxA == IW'(e.idx), idxA, e.idx);
            chkRange("count", cntA, lo, hi);
            chk("ovf8", ovfA == 0, ovfA, 0);
            chk("idx3", idx3 == IW'(e.idx), idx3, e.idx);
            if (lo >= 8) begin
              chk("sat_count3", cnt3 == 7, cnt3, 7);
              chk("ovf3", ovf3 == 1, ovf3, 1);
            end else if (hi <= 7) begin
              chkRange("count3", cnt3, lo, hi);
              chk("ovf3", ovf3 == 0, ovf3, 0);
            end else begin
              chkRange("count3", cnt3, lo, 7);
            end
          end
        end
        hIdx = idxA; hCnt = cntA; hOvf = ovfA;
        holdPrev = !iReady;
        if (iReady && sb.size() != 0) void'(sb.pop_front());
      end else begin
        holdPrev = 0;
      end
    end
  end

  task automatic pushSweeps(input int n);
    for (int s = 0; s < n; s++)
      for (int r = 0; r < NR; r++) sb.push_back('{idx: r, per: per[r]});
  endtask

  task automatic startAndTime(input string nm);
    int n;
    @(posedge iClk); #1 iStart = 1;
    @(posedge iClk); #1 iStart = 0;
    n = 1;
    while (!vldA && n < 400) begin @(posedge iClk); #1; n++; end
    chk(nm, n == LAT, n, LAT);
  endtask

  task automatic waitEmpty(input string nm, input int maxCyc);
    int n = 0;
    while (sb.size() != 0 && n < maxCyc) begin @(posedge iClk); #1; n++; end
    chk(nm, sb.size() == 0, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chkIdle(input string nm);
    repeat (3) @(posedge iClk);
    #1 chk(nm, !busyA && !vldA && roEn == 0 && !busy3, {busyA, vldA, roEn}, 0);
  endtask

  initial begin
    #12;
    chk("rst_out", roEn == 0 && !vldA && !busyA && idxA == 0 && cntA == 0 && !ovfA,
        {roEn, vldA, busyA, idxA, cntA, ovfA}, 0);
    chk("rst_out3", roEn3 == 0 && !vld3 && cnt3 == 0 && !ovf3, {roEn3, vld3, cnt3, ovf3}, 0);
    @(posedge iClk); #1 iRst_n = 1;
    repeat (3) @(posedge iClk);

    // Fixed periods, always ready, one sweep (ring 0 saturates the 3-bit counter, ring 2 does not)
    rdyMode = 0; rdyVal = 1;
    pushSweeps(1);
    startAndTime("latency_t1");
    waitEmpty("drain_t1", 2000);
    chkIdle("idle_t1");

    // Long stall in the first HOLD
    rdyVal = 0;
    pushSweeps(1);
    startAndTime("latency_t2");
    repeat (50) @(posedge iClk);
    #1 chk("stall_valid", vldA && idxA == 0 && roEn == 0, {vldA, idxA, roEn}, 4);
    rdyVal = 1;
    waitEmpty("drain_t2", 2000);
    chkIdle("idle_t2");

    // Continuous: wrap to ring 0 without a new start, then stop before the second last-ring handshake
    iContinuous = 1;
    pushSweeps(2);
    startAndTime("latency_t4");
    begin
      int n = 0;
      while (sb.size() > 1 && n < 3000) begin @(posedge iClk); #1; n++; end
      chk("cont_progress", sb.size() == 1, sb.size(), 1);
    end
    iContinuous = 0;
    waitEmpty("drain_t4", 1000);
    chkIdle("idle_t4");

    // Reset in the middle of ring 2's gate window
    pushSweeps(1);
    @(posedge iClk); #1 iStart = 1;
    @(posedge iClk); #1 iStart = 0;
    begin
      int n = 0;
      while (roEn != 4'b0100 && n < 1000) begin @(posedge iClk); #1; n++; end
      chk("reach_ring2", roEn == 4'b0100, roEn, 4);
    end
    repeat (30) @(posedge iClk);
    #2 iRst_n = 0;
    #1 chk("rst_async", roEn == 0 && !vldA && !busyA && roEn3 == 0, {roEn, vldA, busyA}, 0);
    sb.delete();
    @(posedge iClk); #1 iRst_n = 1;
    repeat (20) @(posedge iClk);
    #1 chk("post_rst_idle", !busyA && !vldA && roEn == 0, {busyA, vldA, roEn}, 0);

    // Random periods, random stalls, stray start pulses while busy
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < NR; r++) per[r] = 2 * $urandom_range(2, 20);
      rdyMode = 1;
      pushSweeps(1);
      startAndTime("latency_rand");
      for (int k = 0; k < 400 && sb.size() != 0; k++) begin
        @(posedge iClk); #1;
        if (sb.size() != 0 && $urandom_range(0, 15) == 0) iStart = 1;
        @(posedge iClk); #1 iStart = 0;
      end
      waitEmpty("drain_rand", 2000);
      rdyMode = 0;
      chkIdle("idle_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
